uart_tx_fifo: RTL
=================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLOCK_DIVIDER_WIDTH, default 16, meaning width of the bit-period divider input.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, legal range 5..9, meaning data bits per frame.
REQ-003 SHALL have parameter FIFO_DEPTH_LOG2, default 4, legal range 1..8, meaning log2 of the transmit FIFO depth.
REQ-004 SHALL have port clock_i, input, width 1, meaning the single clock; all logic is on the rising edge.
REQ-005 SHALL have port reset_i, input, width 1, meaning asynchronous active-high reset.
REQ-006 SHALL have port write_i, input, width 1, meaning push request, qualified by ready_o.
REQ-007 SHALL have port data_i, input, width DATA_WIDTH, meaning the word to push.
REQ-008 SHALL have ports two_stop_bits_i, parity_bit_i and parity_even_i, inputs, width 1 each, meaning frame format, sampled at pop.
REQ-009 SHALL have port clock_divider_i, input, width CLOCK_DIVIDER_WIDTH, meaning clocks per bit.
REQ-010 SHALL have port serial_o, output, width 1, meaning the TX line, idle high.
REQ-011 SHALL have port ready_o, output, width 1, meaning the FIFO can accept a push.
REQ-012 SHALL have port busy_o, output, width 1, meaning the transmitter or FIFO is non-idle.
REQ-013 SHALL have port fifo_count_o, output, width FIFO_DEPTH_LOG2+1, meaning the number of stored words.

Function
REQ-014 SHALL make the bit period max(clock_divider_i,1) clocks; 0 behaves as 1.
REQ-015 SHALL use states POST_RESET, IDLE, SEND and, when the break feature is compiled in, BREAK.
REQ-016 SHALL hold serial_o high in POST_RESET for DATA_WIDTH+4 bit periods, then enter IDLE.
REQ-017 SHALL push data_i when write_i && ready_o; ready_o = !full && state != POST_RESET && !reset_i.
REQ-018 SHALL pop the head word in IDLE when the FIFO is non-empty, latch the format inputs in that cycle, and enter SEND.
REQ-019 SHALL give a push into an empty FIFO in IDLE at cycle N a start-bit falling edge on serial_o at cycle N+2.
REQ-020 SHALL send each frame as: start bit 0, DATA_WIDTH data bits LSB first, optional parity, then 1 or 2 stop bits of 1.
REQ-021 SHALL drive parity = XOR of the data bits when even, and its inverse when odd.
REQ-022 SHALL, after the last stop bit, return to IDLE, and pop the next word if one is present, for back-to-back frames with no idle gap beyond the one IDLE cycle.
REQ-023 SHALL leave the count unchanged on a simultaneous push and pop; a push while full is impossible because ready_o is low.
REQ-024 SHALL keep the FIFO pointers wrapping modulo 2^FIFO_DEPTH_LOG2.
REQ-025 SHALL drive busy_o = reset_i || state != IDLE || fifo_count_o != 0.
REQ-026 SHALL not apply a clock_divider_i change mid-bit; the change takes effect at the next bit boundary.

Reset
REQ-027 SHALL, on reset_i high, immediately set: serial_o=1, ready_o=0, busy_o=1, fifo_count_o=0, FIFO emptied, state=POST_RESET, bit counters cleared.
REQ-028 SHALL, on reset mid-frame, abort the frame, hold the line high, and discard the FIFO contents.

Configuration
REQ-029 SHALL, with macro UART_TX_FIFO_BREAK_EN defined, add input port break_i, width 1.
REQ-030 SHALL, with UART_TX_FIFO_BREAK_EN defined, have break_i sampled only in IDLE with priority over pop: it enters BREAK and drives serial_o=0 for at least DATA_WIDTH+4 bit periods and while break_i stays high, then drives 1 for one bit period and returns to IDLE.
REQ-031 SHALL, without UART_TX_FIFO_BREAK_EN, have no break_i port and no BREAK state; the line is never held low beyond a frame.

Verification
REQ-032 SHALL cover: reset, divider=4 -> serial_o high for 48 clocks, ready_o rises after POST_RESET.
REQ-033 SHALL cover: divider=4, no parity, 1 stop, push 0x55 -> serial_o 0,1,0,1,0,1,0,1,0,1, each 4 clocks, 40 clocks, start edge 2 cycles after push.
REQ-034 SHALL cover: parity even, push 0x07 -> parity bit 1; parity odd -> 0; two_stop_bits=1 -> 12-bit frame.
REQ-035 SHALL cover: FIFO_DEPTH_LOG2=2, push 5 words during a frame -> ready_o low at count 4, all words sent back-to-back in order.
REQ-036 SHALL cover: reset asserted mid data bit 3 -> serial_o=1 and fifo_count_o=0 in the same cycle, then a POST_RESET delay.
REQ-037 SHALL cover, when UART_TX_FIFO_BREAK_EN is defined: divider=2, break_i pulse of 1 clock -> serial_o low 24 clocks, then high 2 clocks, then IDLE.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a FIFO; optional line break via UART_TX_FIFO_BREAK_EN.
// Latency: a push into an empty idle FIFO starts the start bit two cycles later.
// Backpressure: ready low while full, in POST_RESET, or in reset.
module uart_tx_fifo #(
  parameter int CLOCK_DIVIDER_WIDTH = 16,
  parameter int DATA_WIDTH          = 8,
  parameter int FIFO_DEPTH_LOG2     = 4
) (
  input  logic                           clock_i,
  input  logic                           reset_i,
  input  logic                           write_i,
  input  logic [DATA_WIDTH-1:0]          data_i,
  input  logic                           two_stop_bits_i,
  input  logic                           parity_bit_i,
  input  logic                           parity_even_i,
  input  logic [CLOCK_DIVIDER_WIDTH-1:0] clock_divider_i,
`ifdef UART_TX_FIFO_BREAK_EN
  input  logic                           break_i,
`endif
  output logic                           serial_o,
  output logic                           ready_o,
  output logic                           busy_o,
  output logic [FIFO_DEPTH_LOG2:0]       fifo_count_o
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam logic [FIFO_DEPTH_LOG2:0] FULL_COUNT = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};

`ifdef UART_TX_FIFO_BREAK_EN
  typedef enum logic [1:0] {POST_RESET, IDLE, SEND, BREAK} state_t;
`else
  typedef enum logic [1:0] {POST_RESET, IDLE, SEND} state_t;
`endif

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0]          mem [0:DEPTH-1];
  logic [FIFO_DEPTH_LOG2-1:0]     wr_ptr, rd_ptr;
  logic [FIFO_DEPTH_LOG2:0]       count;
  logic                           full, empty, push, pop;

  logic [CLOCK_DIVIDER_WIDTH-1:0] clk_cnt_q, clk_cnt_d;
  logic [CLOCK_DIVIDER_WIDTH-1:0] period_q, period_d;
  logic [CLOCK_DIVIDER_WIDTH-1:0] live_period, cur_period;
  logic [3:0]                     bit_idx_q, bit_idx_d, nxt_idx, last_idx;
  logic [DATA_WIDTH-1:0]          shift_q, shift_d;
  logic                           par_en_q, par_en_d;
  logic                           par_val_q, par_val_d;
  logic                           stop2_q, stop2_d;
  logic                           serial_q, serial_d;
  logic                           bit_end;

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);
  assign push  = write_i && ready_o;

  always_ff @(posedge clock_i) begin
    if (push) mem[wr_ptr] <= data_i;
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A zero period register means no bit has been timed since reset yet.
  assign live_period = (clock_divider_i == '0) ? CLOCK_DIVIDER_WIDTH'(1) : clock_divider_i;
  assign cur_period  = (period_q == '0) ? live_period : period_q;
  assign bit_end     = (clk_cnt_q == cur_period - 1'b1);
  assign nxt_idx     = bit_idx_q + 4'd1;
  assign last_idx    = 4'(DATA_WIDTH) + {3'b000, par_en_q} + (stop2_q ? 4'd2 : 4'd1);

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    period_d  = period_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    par_val_d = par_val_q;
    stop2_d   = stop2_q;
    serial_d  = serial_q;
    pop       = 1'b0;

    if (state_q != IDLE) begin
      if (bit_end) begin
        clk_cnt_d = '0;
        period_d  = live_period;
      end else begin
        clk_cnt_d = clk_cnt_q + 1'b1;
      end
    end

    case (state_q)
      POST_RESET: begin
        serial_d = 1'b1;
        if (bit_end) begin
          if (bit_idx_q == 4'(DATA_WIDTH + 3)) begin
            state_d   = IDLE;
            bit_idx_d = '0;
          end else begin
            bit_idx_d = nxt_idx;
          end
        end
      end
      IDLE: begin
        serial_d  = 1'b1;
        clk_cnt_d = '0;
        bit_idx_d = '0;
`ifdef UART_TX_FIFO_BREAK_EN
        if (break_i) begin
          state_d  = BREAK;
          serial_d = 1'b0;
          period_d = live_period;
        end else
`endif
        if (!empty) begin
          pop       = 1'b1;
          state_d   = SEND;
          serial_d  = 1'b0;
          period_d  = live_period;
          shift_d   = mem[rd_ptr];
          par_en_d  = parity_bit_i;
          stop2_d   = two_stop_bits_i;
          par_val_d = (^mem[rd_ptr]) ^ ~parity_even_i;
        end
      end
      SEND: begin
        if (bit_end) begin
          if (bit_idx_q == last_idx) begin
            state_d   = IDLE;
            serial_d  = 1'b1;
            bit_idx_d = '0;
          end else begin
            bit_idx_d = nxt_idx;
            if (nxt_idx <= 4'(DATA_WIDTH)) begin
              serial_d = shift_q[0];
              shift_d  = shift_q >> 1;
            end else if (nxt_idx == 4'(DATA_WIDTH + 1) && par_en_q) begin
              serial_d = par_val_q;
            end else begin
              serial_d = 1'b1;
            end
          end
        end
      end
`ifdef UART_TX_FIFO_BREAK_EN
      BREAK: begin
        // Low for the minimum length and while break_i holds, then one high bit.
        if (bit_end) begin
          if (serial_q) begin
            state_d   = IDLE;
            bit_idx_d = '0;
          end else if (bit_idx_q >= 4'(DATA_WIDTH + 3) && !break_i) begin
            serial_d = 1'b1;
          end else if (bit_idx_q < 4'(DATA_WIDTH + 3)) begin
            bit_idx_d = nxt_idx;
          end
        end
      end
`endif
      default: begin
        state_d  = POST_RESET;
        serial_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= POST_RESET;
      clk_cnt_q <= '0;
      period_q  <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_val_q <= 1'b0;
      stop2_q   <= 1'b0;
      serial_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      period_q  <= period_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      par_val_q <= par_val_d;
      stop2_q   <= stop2_d;
      serial_q  <= serial_d;
    end
  end

  assign serial_o     = serial_q;
  assign ready_o      = !full && (state_q != POST_RESET) && !reset_i;
  assign busy_o       = reset_i || (state_q != IDLE) || (count != '0);
  assign fifo_count_o = count;

endmodule
